// File: rtl/mux2_1_2bit_rr_arbiter.sv
// ============================================================================
// mux2_1_2bit_rr_arbiter: round-robin burst arbiter driving a registered
// 2-bit 2:1 mux channel with valid/ready on both sides.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mux2_1_2bit_rr_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int BURST_W   = 2
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic [1:0] in0_data,
  input  logic       in0_valid,
  output logic       in0_ready,
  input  logic [1:0] in1_data,
  input  logic       in1_valid,
  output logic       in1_ready,
  output logic [1:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       selector
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  localparam logic [BURST_W-1:0] LAST_CNT = BURST_W'(MAX_BURST - 1);

  state_t             state_q, state_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic               ptr_q, ptr_d;
  logic [1:0]         out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;

  logic load;
  logic xfer0;
  logic xfer1;
  logic xfer;

  assign load      = !out_valid_q || out_ready;
  assign in0_ready = (state_q == G0) && load;
  assign in1_ready = (state_q == G1) && load;
  assign xfer0     = in0_valid && in0_ready;
  assign xfer1     = in1_valid && in1_ready;
  assign xfer      = xfer0 || xfer1;

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign selector  = (state_q == G1);

  // Grant / burst / priority-pointer next state
  always_comb begin
    logic   cur_valid;
    logic   oth_valid;
    logic   oth_idx;
    state_t oth_state;

    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    cur_valid = (state_q == G1) ? in1_valid : in0_valid;
    oth_valid = (state_q == G1) ? in0_valid : in1_valid;
    oth_idx   = (state_q == G0);
    oth_state = (state_q == G1) ? G0 : G1;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (in0_valid && in1_valid) begin
          state_d = ptr_q ? G1 : G0;
        end else if (in0_valid) begin
          state_d = G0;
        end else if (in1_valid) begin
          state_d = G1;
        end
      end
      G0, G1: begin
        if (xfer) begin
          if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
            if (oth_valid) begin
              state_d = oth_state;
              ptr_d   = oth_idx;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (!cur_valid) begin
          cnt_d   = '0;
          ptr_d   = oth_idx;
          state_d = oth_valid ? oth_state : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Single output stage; a load slot without a transfer drains the word
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (load) begin
      out_valid_d = xfer;
      if (xfer0) begin
        out_data_d = in0_data;
      end else if (xfer1) begin
        out_data_d = in1_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= 1'b0;
      out_data_q  <= 2'b00;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

`default_nettype wire

// File: doc/mux2_1_2bit_rr_arbiter.md
Name: mux2_1_2bit_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one registered 2-bit 2:1 mux channel between two requesters.
- Each requester uses a valid/ready handshake. The block drives the mux select, holds a grant for a bounded burst, and registers the winning data into a single output stage with downstream backpressure.
- Sits in front of the registered-mux datapath and replaces a free-running selector with a controlled one.

Parameters:
- MAX_BURST, 4, maximum consecutive transfers per grant before forced re-arbitration; legal range 1..4.
- BURST_W, 2, width of the burst counter; must satisfy 2^BURST_W >= MAX_BURST.

Ports:
- clk  input  1  single clock, rising edge
- reset_L  input  1  asynchronous active-low reset
- in0_data  input  2  requester 0 data
- in0_valid  input  1  requester 0 has data
- in0_ready  output  1  requester 0 transfer accepted this cycle
- in1_data  input  2  requester 1 data
- in1_valid  input  1  requester 1 has data
- in1_ready  output  1  requester 1 transfer accepted this cycle
- out_data  output  2  registered mux output
- out_valid  output  1  out_data holds a word
- out_ready  input  1  downstream accepts out_data
- selector  output  1  current grant index, drives the mux select; 0 when idle

Behaviour:
- Reset (reset_L=0, asynchronous, any cycle):
  - state=IDLE, burst count=0, priority pointer=0.
  - out_data=2'b00, out_valid=0, selector=0.
  - in0_ready=in1_ready=0 while in reset.
  - Any word in the output register is discarded.
- Load enable: load = !out_valid | out_ready.
- Ready and transfer:
  - ink_ready = (state==Gk) & load, combinational.
  - Transfer on input k = ink_valid & ink_ready.
- On transfer: out_data<=ink_data and out_valid<=1 next edge.
- On load with no transfer: out_valid<=0 next edge.
- When !load: out_data and out_valid hold.
- States: IDLE, G0, G1, 2-bit encoded, grant registered.
- IDLE transitions:
  - Both valid -> G(pointer).
  - Only ink_valid -> Gk.
  - None -> stay IDLE.
  - No transfer occurs in IDLE, so first-word latency is request cycle N, grant N+1, transfer N+1 if load, out_valid N+2.
- Gk, transfer with count==MAX_BURST-1 (burst end):
  - Other input valid -> G(other), count=0, pointer=k's opponent. No bubble cycle.
  - Otherwise stay in Gk, count=0, no bubble.
- Gk, transfer with count<MAX_BURST-1: count+1, stay.
- Gk, ink_valid=0:
  - Other valid -> G(other), count=0.
  - Otherwise -> IDLE, count=0.
  - Pointer = other index in both cases.
- Gk, ink_valid=1 and !load: hold state, count, and pointer.
- Count increments only on a transfer; a stall never advances it.
- selector = 1 only in G1.
- Protocol: requesters keep data stable and valid high until accepted. This is not checked.
- MAX_BURST=1: re-arbitrate after every transfer, giving strict alternation when both are valid.

Test Plan:
- Reset mid-burst: in G0 with count=2, pull reset_L low between edges -> immediately out_valid=0, out_data=00, selector=0, in0_ready=0. After release, the first grant goes to in0 if both are valid.
- Single stream: in0_valid=1 with data 01,10,11,00,01, out_ready=1, in1 idle -> out_data 01,10,11,00,01 on consecutive cycles from the 2nd cycle after the request. Selector stays 0 and there is no bubble at the burst boundary.
- Contention: both valid constantly, in0_data=01, in1_data=10, MAX_BURST=4, out_ready=1 -> out sequence 01x4, 10x4, 01x4 with no idle cycle. Selector toggles every 4 transfers.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles during G1 -> out_data frozen, in1_ready=0, count unchanged. After out_ready=1 the stream resumes with no lost or duplicated word.
- Early release: G0 after 2 transfers, in0_valid drops, in1_valid=1 with data 11 -> next cycle selector=1 and in1_ready=1, out_data=11 one cycle later, count restarted.
- Fairness from IDLE: both valid in the first cycle after reset -> G0 wins. in0 is released via valid low, all go idle, then both request again -> G1 wins.
